// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared widths and write-back entry layout for the GPR write-back path
//
// Purpose : default GPR data/index widths, the {rd, data} write-back entry
//           layout and a helper that sizes an entry for arbitrary widths.
// Ports   : none (package).
package gpr_pkg;

    localparam int GPR_ISA_WIDTH      = 32;
    localparam int GPR_REG_NUM_WIDTH  = 5;
    localparam int GPR_WB_FIFO_DEPTH  = 2;

    // Entry layout: destination index in the upper bits, result data below.
    typedef struct packed {
        logic [GPR_REG_NUM_WIDTH-1:0] rd;
        logic [GPR_ISA_WIDTH-1:0]     data;
    } wb_entry_t;

    localparam int WB_ENTRY_WIDTH = $bits(wb_entry_t);

    // Entry width for a non-default parameterisation of the write-back unit.
    function automatic int wb_entry_width(input int isa_width, input int reg_num_width);
        return isa_width + reg_num_width;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - generic synchronous FIFO with asynchronous active-low reset
//
// Purpose : small first-in first-out buffer; head is combinational from the
//           storage registers, full/empty derive from an occupancy counter.
// Ports   : clk, rst (async, active low)
//           push, push_data  - enqueue request and payload
//           pop              - dequeue the head entry
//           full, empty      - occupancy flags
//           head             - entry at the read pointer
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is accepted when it is paired with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gpr_wb_unit.sv
// rtl/gpr_wb_unit.sv - GPR write-back: ALU/LSU arbitration, buffering, commit and scoreboard
//
// Purpose : accepts ALU and LSU results (LSU has fixed priority), drops x0
//           results, buffers the rest in wb_fifo and commits one register
//           write per cycle; tracks pending destinations for decode hazards.
// Ports   : clk, rst (async, active low)
//           issue_valid/issue_rd/issue_ready - decode reserves a destination
//           alu_valid/alu_rd/alu_data/alu_ready - ALU result stream
//           lsu_valid/lsu_rd/lsu_data/lsu_ready - load result stream
//           wb_hold                          - freeze commits
//           wen/waddr/wdata                  - register file write port
//           raddr_1/busy_1, raddr_2/busy_2   - hazard lookups
//           sb_err                           - sticky write-back to a non-pending register
module gpr_wb_unit
    import gpr_pkg::*;
#(
    parameter int ISA_WIDTH          = GPR_ISA_WIDTH,
    parameter int REGISTER_NUM_WIDTH = GPR_REG_NUM_WIDTH,
    parameter int FIFO_DEPTH         = GPR_WB_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [REGISTER_NUM_WIDTH-1:0] issue_rd,
    output logic                          issue_ready,
    input  logic                          alu_valid,
    input  logic [REGISTER_NUM_WIDTH-1:0] alu_rd,
    input  logic [ISA_WIDTH-1:0]          alu_data,
    output logic                          alu_ready,
    input  logic                          lsu_valid,
    input  logic [REGISTER_NUM_WIDTH-1:0] lsu_rd,
    input  logic [ISA_WIDTH-1:0]          lsu_data,
    output logic                          lsu_ready,
    input  logic                          wb_hold,
    output logic                          wen,
    output logic [REGISTER_NUM_WIDTH-1:0] waddr,
    output logic [ISA_WIDTH-1:0]          wdata,
    input  logic [REGISTER_NUM_WIDTH-1:0] raddr_1,
    output logic                          busy_1,
    input  logic [REGISTER_NUM_WIDTH-1:0] raddr_2,
    output logic                          busy_2,
    output logic                          sb_err
);

    localparam int ENTRY_W   = wb_entry_width(ISA_WIDTH, REGISTER_NUM_WIDTH);
    localparam int REG_COUNT = 1 << REGISTER_NUM_WIDTH;

    logic                          fifo_full;
    logic                          fifo_empty;
    logic [ENTRY_W-1:0]            head;
    logic                          lsu_fire;
    logic                          alu_fire;
    logic                          push;
    logic [REGISTER_NUM_WIDTH-1:0] push_rd;
    logic [ISA_WIDTH-1:0]          push_data;
    logic                          issue_fire;
    logic [REG_COUNT-1:0]          pending;
    logic [REG_COUNT-1:0]          pending_next;

    assign lsu_ready = !fifo_full;
    assign alu_ready = !fifo_full && !lsu_valid;
    assign lsu_fire  = lsu_valid && lsu_ready;
    assign alu_fire  = alu_valid && alu_ready;

    // At most one of the two fires; x0 results complete the handshake
    // but never reach the buffer.
    assign push_rd   = lsu_fire ? lsu_rd   : alu_rd;
    assign push_data = lsu_fire ? lsu_data : alu_data;
    assign push      = (lsu_fire || alu_fire) && (push_rd != '0);

    assign wen   = !fifo_empty && !wb_hold;
    assign waddr = head[ENTRY_W-1 -: REGISTER_NUM_WIDTH];
    assign wdata = head[ISA_WIDTH-1:0];

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({push_rd, push_data}),
        .pop       (wen),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign issue_ready = !pending[issue_rd];
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
    assign busy_1      = pending[raddr_1];
    assign busy_2      = pending[raddr_2];

    // Clear is applied after set so a commit always wins over a reservation.
    always_comb begin
        pending_next = pending;
        if (issue_fire) begin
            pending_next[issue_rd] = 1'b1;
        end
        if (wen) begin
            pending_next[waddr] = 1'b0;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            pending <= pending_next;
            if (push && !pending[push_rd]) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule
